// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared helpers for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_addsub_pkg;

    // Bits rippled by each pipeline slice.
    function automatic int slice_bits(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_rca_addsub_rca_slice.sv
// Combinational S-bit ripple-carry chain, one per pipeline slice.
module rca_slice #(
    parameter int S = 4
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         ci,
    output logic [S-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [S:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_bit
            assign s[gi]     = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co       = c[S];
    // Carry into the top bit; XOR with co gives signed overflow.
    assign c_msb_in = c[S-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// N-bit add/subtract split into STAGES ripple slices with valid/ready flow
// control; each stage holds finished low sum bits plus untouched upper operands.
module pipelined_rca_addsub
    import pipelined_rca_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S = slice_bits(WIDTH, STAGES);

    logic [WIDTH-1:0] b_cond;
    logic             c0;

    assign b_cond = sub ? ~in2 : in2;
    assign c0     = sub ? 1'b1 : cin;

    // word_q[k]: sum bits below (k+1)*S, operand A bits above.
    logic [WIDTH-1:0]  word_q [STAGES];
    logic [WIDTH-1:0]  word_d [STAGES];
    logic [WIDTH-1:0]  bop_q  [STAGES];
    logic [WIDTH-1:0]  bop_d  [STAGES];
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic              ovf_q, ovf_d;
    logic [STAGES:0]   rdy;

    assign rdy[STAGES] = out_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic             c_in;
            logic             v_in;
            logic [S-1:0]     s_w;
            logic             co_w;
            logic             cm_w;
            logic [WIDTH-1:0] merged;

            if (gi == 0) begin : g_head
                assign a_in = in1;
                assign b_in = b_cond;
                assign c_in = c0;
                assign v_in = in_valid;
            end else begin : g_body
                assign a_in = word_q[gi-1];
                assign b_in = bop_q[gi-1];
                assign c_in = c_q[gi-1];
                assign v_in = v_q[gi-1];
            end

            assign rdy[gi] = !v_q[gi] | rdy[gi + 1];

            rca_slice #(.S(S)) u_slice (
                .a        (a_in[gi*S +: S]),
                .b        (b_in[gi*S +: S]),
                .ci       (c_in),
                .s        (s_w),
                .co       (co_w),
                .c_msb_in (cm_w)
            );

            always_comb begin
                merged             = a_in;
                merged[gi*S +: S]  = s_w;
            end

            assign v_d[gi]    = rdy[gi] ? v_in   : v_q[gi];
            assign c_d[gi]    = rdy[gi] ? co_w   : c_q[gi];
            assign word_d[gi] = rdy[gi] ? merged : word_q[gi];
            assign bop_d[gi]  = rdy[gi] ? b_in   : bop_q[gi];

            if (gi == STAGES - 1) begin : g_flag
                assign ovf_d = rdy[gi] ? (cm_w ^ co_w) : ovf_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
                bop_q[k]  <= '0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= word_d[k];
                bop_q[k]  <= bop_d[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = word_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Directed-vector and scoreboard bench for pipelined_rca_addsub (16 bits, 4 stages).
module tb_pipelined_rca_addsub;

    localparam int W  = 16;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1, in2;
    logic         cin, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf;

    pipelined_rca_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        logic         o;
        bb   = s ? ~b : b;
        cc   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        o    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    typedef struct {
        logic [W+1:0] exp;
        int           acc_cyc;
    } sb_t;

    sb_t q[$];
    int  ocyc[$];
    bit  sb_en      = 1'b0;
    int  last_stall = -1;
    int  n_out      = 0;

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    n_out++;
                    check("sb_sum",  {16'd0, sum}, {16'd0, e.exp[W-1:0]});
                    check("sb_cout", {31'd0, cout}, {31'd0, e.exp[W]});
                    check("sb_ovf",  {31'd0, ovf},  {31'd0, e.exp[W+1]});
                    check("sb_lat_min", {31'd0, (cyc - e.acc_cyc) >= ST}, 32'd1);
                    if (last_stall <= e.acc_cyc)
                        check("sb_latency", cyc - e.acc_cyc, ST);
                    ocyc.push_back(cyc);
                end
            end
            if (out_valid && !out_ready) last_stall = cyc;
            if (in_valid && in_ready) begin
                sb_t n;
                n.exp     = model(in1, in2, cin, sub);
                n.acc_cyc = cyc;
                q.push_back(n);
            end
        end
    end

    // Presents a beat and returns at posedge+1 after the edge that took it.
    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic s);
        bit ok;
        in1 = a; in2 = b; cin = c; sub = s; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         c, s;
        logic [W-1:0] exp_sum;
        logic         exp_cout, exp_ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [W-1:0] held;
        int           lat;
        int           acc;
        bit           took;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_sum",       {16'd0, sum},       32'd0);
        check("reset_cout",      {31'd0, cout},      32'd0);
        check("reset_ovf",       {31'd0, ovf},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, one at a time into an empty pipe.
        for (int v = 0; v < 12; v++) begin
            drive_beat(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].s);
            in_valid = 1'b0;
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                lat++;
                if (out_valid) break;
            end
            check($sformatf("vec%0d_latency", v), lat, ST);
            check($sformatf("vec%0d_sum", v),  {16'd0, sum},  {16'd0, vecs[v].exp_sum});
            check($sformatf("vec%0d_cout", v), {31'd0, cout}, {31'd0, vecs[v].exp_cout});
            check($sformatf("vec%0d_ovf", v),  {31'd0, ovf},  {31'd0, vecs[v].exp_ovf});
            $display("[TB] vec%0d a=%04h b=%04h cin=%0b sub=%0b -> sum=%04h cout=%0b ovf=%0b lat=%0d",
                     v, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].s, sum, cout, ovf, lat);
            @(posedge clk); #1;
        end

        // Backpressure: fill the pipe, hold the output, then release.
        q.delete(); ocyc.delete(); sb_en = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            drive_beat(16'h1000 * i + 16'h0123, 16'h0F0F + i, i[0], i[1]);
        in1 = 16'h9ABC; in2 = 16'h1111; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        held = sum;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_in_ready_low", {31'd0, in_ready},  32'd0);
            check("bp_out_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_sum_stable",   {16'd0, sum},       {16'd0, held});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_full_pass_through", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive_beat(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("bp_drained", q.size(), 0);
        check("bp_out_count", ocyc.size(), 6);
        if (ocyc.size() == 6)
            for (int i = 1; i < 6; i++) check("bp_back_to_back", ocyc[i] - ocyc[0], i);
        $display("[TB] backpressure: %0d results emitted", ocyc.size());
        sb_en = 1'b0;

        // Asynchronous reset with the pipe full and a result on the output.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(16'h1111, 16'h2222, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_sum",       {16'd0, sum},       32'd0);
        check("midreset_cout",      {31'd0, cout},      32'd0);
        check("midreset_ovf",       {31'd0, ovf},       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_stale_beat", {31'd0, out_valid}, 32'd0);
        end
        $display("[TB] mid-stream reset: pipe flushed");

        // Random soak with random valid and backpressure.
        @(posedge clk); #1;
        q.delete(); ocyc.delete(); n_out = 0; sb_en = 1'b1;
        acc = 0;
        in_valid = 1'b0;
        for (int g = 0; g < 60000; g++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) acc++;
            if (acc >= 10000) begin
                in_valid = 1'b0;
                break;
            end
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in1 = W'($urandom);
                in2 = W'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("soak_accepted", acc, 10000);
        check("soak_drained", q.size(), 0);
        check("soak_out_count", n_out, 10000);
        $display("[TB] soak: %0d accepted, %0d emitted", acc, n_out);
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
